pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_skid_reg.sv | 96 +++++++++
 tb/tb_pipe_skid_reg.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// State encoding shared by pipeline stages, plus a helper that maps a state to its entry count.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

   function automatic logic [1:0] state_occupancy(input pipe_state_e st);
      logic [1:0] occ;
      occ = 2'd0;
      unique case (st)
         EMPTY:   occ = 2'd0;
         FULL:    occ = 2'd1;
         SKID:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register. The SKID=1 build has a two-entry skid and an in_ready that comes
// only from registers. The SKID=0 build has one entry and an in_ready that is combinational.
module pipe_skid_reg #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SKID  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   pipe_pkg::pipe_state_e state_q, state_d;
   logic [WIDTH-1:0]      main_q, main_d;
   logic [WIDTH-1:0]      skid_q, skid_d;
   logic                  in_fire;
   logic                  out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_skid
         assign in_ready = (state_q != pipe_pkg::SKID);
      end else begin : g_flow
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= pipe_pkg::EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         pipe_pkg::EMPTY: begin
            if (in_fire) begin
               state_d = pipe_pkg::FULL;
               main_d  = in_data;
            end
         end
         pipe_pkg::FULL: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               // When SKID=0, in_ready is low in FULL without out_ready, so this branch never runs.
               if (SKID != 0) begin
                  state_d = pipe_pkg::SKID;
                  skid_d  = in_data;
               end
            end else if (out_fire) begin
               state_d = pipe_pkg::EMPTY;
            end
         end
         pipe_pkg::SKID: begin
            if (out_fire) begin
               state_d = pipe_pkg::FULL;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = pipe_pkg::EMPTY;
         end
      endcase
      // Flush wins over every handshake. An in_fire in this cycle is dropped.
      if (flush) begin
         state_d = pipe_pkg::EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
   end

   always_comb begin
      out_valid = (state_q != pipe_pkg::EMPTY);
      out_data  = main_q;
      occupancy = pipe_pkg::state_occupancy(state_q);
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for both builds of pipe_skid_reg: index 1 is SKID=1 and index 0 is SKID=0. A monitor keeps
// a queue scoreboard, and directed sequences check values worked out by hand.
module tb_pipe_skid_reg;

   logic             clk;
   logic             rst;
   logic [1:0]       flush;
   logic [1:0]       in_valid;
   logic [1:0][31:0] in_data;
   logic [1:0]       out_ready;
   wire  [1:0]       in_ready;
   wire  [1:0]       out_valid;
   wire  [1:0][31:0] out_data;
   wire  [1:0][1:0]  occupancy;

   int               n_checks;
   int               n_err;
   logic             armed;
   logic [31:0]      mq [2][$];
   logic [31:0]      last_main [2];

   pipe_skid_reg #(.WIDTH(32), .SKID(1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[1]),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_data   (in_data[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_data  (out_data[1]),
      .occupancy (occupancy[1])
   );

   pipe_skid_reg #(.WIDTH(32), .SKID(0)) u_flow (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[0]),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_data   (in_data[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_data  (out_data[0]),
      .occupancy (occupancy[0])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge. Directed checks run 2 units later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor and scoreboard. Comparisons happen on the falling edge, then the model advances to
   // match the coming rising edge.
   always @(negedge clk) begin
      if (armed) begin
         for (int i = 0; i < 2; i++) begin
            int          n;
            logic        exp_ir;
            logic [31:0] exp_data;
            n        = mq[i].size();
            exp_ir   = (i == 1) ? (n < 2) : ((n == 0) || out_ready[i]);
            exp_data = (n != 0) ? mq[i][0] : last_main[i];
            chk($sformatf("mon%0d out_valid", i), {31'd0, out_valid[i]}, {31'd0, n != 0});
            chk($sformatf("mon%0d occupancy", i), {30'd0, occupancy[i]}, n);
            chk($sformatf("mon%0d in_ready", i), {31'd0, in_ready[i]}, {31'd0, exp_ir});
            chk($sformatf("mon%0d out_data", i), out_data[i], exp_data);
            if (!rst && (n != 0) && out_ready[i]) begin
               last_main[i] = mq[i].pop_front();
            end
            if (!rst && !flush[i] && in_valid[i] && exp_ir) begin
               mq[i].push_back(in_data[i]);
            end
            if (rst || flush[i]) begin
               mq[i].delete();
               last_main[i] = '0;
            end
         end
      end
   end

   initial begin
      logic ir;
      n_checks     = 0;
      n_err        = 0;
      armed        = 1'b0;
      last_main[0] = '0;
      last_main[1] = '0;
      rst          = 1'b1;
      flush        = '0;
      in_valid     = '0;
      in_data      = '0;
      out_ready    = '0;
      step();
      armed = 1'b1;
      #2;
      for (int i = 0; i < 2; i++) begin
         chk("reset out_valid", {31'd0, out_valid[i]}, 32'd0);
         chk("reset out_data", out_data[i], 32'd0);
         chk("reset occupancy", {30'd0, occupancy[i]}, 32'd0);
         chk("reset in_ready", {31'd0, in_ready[i]}, 32'd1);
      end
      step();
      rst = 1'b0;

      // Back-to-back streaming through the skid build.
      out_ready[1] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         in_valid[1] = 1'b1;
         in_data[1]  = k;
         #2;
         chk("stream in_ready", {31'd0, in_ready[1]}, 32'd1);
         if (k == 1) begin
            chk("stream first empty", {31'd0, out_valid[1]}, 32'd0);
         end else begin
            chk("stream out_valid", {31'd0, out_valid[1]}, 32'd1);
            chk("stream out_data", out_data[1], k - 1);
         end
      end
      step();
      in_valid[1] = 1'b0;
      #2;
      chk("stream last data", out_data[1], 32'd8);
      step();
      #2;
      chk("stream drained", {31'd0, out_valid[1]}, 32'd0);

      // Fill the skid entry, then release it.
      step();
      in_valid[1]  = 1'b1;
      in_data[1]   = 32'hA;
      out_ready[1] = 1'b0;
      #2;
      chk("skid start occ", {30'd0, occupancy[1]}, 32'd0);
      step();
      in_data[1] = 32'hB;
      #2;
      chk("skid A main", out_data[1], 32'hA);
      chk("skid occ1", {30'd0, occupancy[1]}, 32'd1);
      step();
      in_valid[1] = 1'b0;
      #2;
      chk("skid occ2", {30'd0, occupancy[1]}, 32'd2);
      chk("skid in_ready low", {31'd0, in_ready[1]}, 32'd0);
      chk("skid A held", out_data[1], 32'hA);
      step();
      #2;
      chk("skid A still held", out_data[1], 32'hA);
      chk("skid occ2 held", {30'd0, occupancy[1]}, 32'd2);
      step();
      out_ready[1] = 1'b1;
      #2;
      chk("skid emit A", out_data[1], 32'hA);
      chk("skid in_ready still low", {31'd0, in_ready[1]}, 32'd0);
      step();
      #2;
      chk("skid emit B", out_data[1], 32'hB);
      chk("skid in_ready back", {31'd0, in_ready[1]}, 32'd1);
      step();
      #2;
      chk("skid empty", {30'd0, occupancy[1]}, 32'd0);

      // Flush while in the skid state, with 0xC waiting at the input.
      step();
      in_valid[1]  = 1'b1;
      in_data[1]   = 32'h1;
      out_ready[1] = 1'b0;
      step();
      in_data[1] = 32'h2;
      step();
      in_data[1] = 32'hC;
      flush[1]   = 1'b1;
      #2;
      chk("flush pre occ", {30'd0, occupancy[1]}, 32'd2);
      chk("flush in_ready", {31'd0, in_ready[1]}, 32'd0);
      step();
      flush[1]    = 1'b0;
      in_valid[1] = 1'b0;
      #2;
      chk("flush out_valid", {31'd0, out_valid[1]}, 32'd0);
      chk("flush occ", {30'd0, occupancy[1]}, 32'd0);
      chk("flush out_data", out_data[1], 32'd0);
      // Flush in FULL while an input handshake fires; that word must be dropped.
      step();
      in_valid[1] = 1'b1;
      in_data[1]  = 32'h5;
      step();
      in_data[1] = 32'hD;
      flush[1]   = 1'b1;
      #2;
      chk("flush2 in_ready", {31'd0, in_ready[1]}, 32'd1);
      step();
      flush[1]     = 1'b0;
      in_valid[1]  = 1'b0;
      out_ready[1] = 1'b1;
      #2;
      chk("flush2 out_valid", {31'd0, out_valid[1]}, 32'd0);
      chk("flush2 out_data", out_data[1], 32'd0);
      step();
      step();
      #2;
      chk("flush2 no 0xD", {31'd0, out_valid[1]}, 32'd0);

      // Backpressure on the single-entry build.
      step();
      in_valid[0]  = 1'b1;
      in_data[0]   = 32'h11;
      out_ready[0] = 1'b0;
      #2;
      chk("flow in_ready empty", {31'd0, in_ready[0]}, 32'd1);
      step();
      in_data[0] = 32'h22;
      #2;
      chk("flow out_data 11", out_data[0], 32'h11);
      chk("flow in_ready blocked", {31'd0, in_ready[0]}, 32'd0);
      step();
      #2;
      chk("flow still blocked", {31'd0, in_ready[0]}, 32'd0);
      out_ready[0] = 1'b1;
      #1;
      chk("flow comb in_ready", {31'd0, in_ready[0]}, 32'd1);
      step();
      in_valid[0] = 1'b0;
      #2;
      chk("flow replaced", out_data[0], 32'h22);
      chk("flow occ", {30'd0, occupancy[0]}, 32'd1);
      step();
      #2;
      chk("flow drained", {31'd0, out_valid[0]}, 32'd0);

      // Reset while the skid build holds two entries.
      step();
      in_valid[1]  = 1'b1;
      in_data[1]   = 32'h31;
      out_ready[1] = 1'b0;
      step();
      in_data[1] = 32'h32;
      step();
      in_data[1]   = 32'h33;
      out_ready[1] = 1'b1;
      rst          = 1'b1;
      #2;
      chk("rst pre occ", {30'd0, occupancy[1]}, 32'd2);
      step();
      rst         = 1'b0;
      in_valid[1] = 1'b0;
      #2;
      chk("rst out_valid", {31'd0, out_valid[1]}, 32'd0);
      chk("rst out_data", out_data[1], 32'd0);
      chk("rst in_ready", {31'd0, in_ready[1]}, 32'd1);
      chk("rst occ", {30'd0, occupancy[1]}, 32'd0);
      repeat (3) step();
      #2;
      chk("rst no stale", {31'd0, out_valid[1]}, 32'd0);

      // Random traffic on both builds. The scoreboard checks order; the toggle checks that
      // in_ready on the skid build does not follow out_ready.
      for (int c = 0; c < 10000; c++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            in_valid[i]  = ($urandom_range(0, 99) < 70);
            in_data[i]   = $urandom;
            out_ready[i] = ($urandom_range(0, 99) < 60);
            flush[i]     = ($urandom_range(0, 255) == 0);
         end
         #1;
         ir           = in_ready[1];
         out_ready[1] = ~out_ready[1];
         #1;
         chk("in_ready vs out_ready", {31'd0, in_ready[1]}, {31'd0, ir});
         out_ready[1] = ~out_ready[1];
      end
      step();
      in_valid  = '0;
      flush     = '0;
      out_ready = 2'b11;
      repeat (4) step();
      #2;
      chk("drain skid", mq[1].size(), 32'd0);
      chk("drain flow", mq[0].size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
